// File: rtl/rx_buffer_mlane.sv
// rx_buffer_mlane
// Multi-lane RX packet buffer between the deframer and the DLL interface.
// Accepts up to WR_LANES deframed entries per cycle and presents them one per
// cycle, in write order, on show-ahead head outputs.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   i_Flush             synchronous flush, same effect as RST
//   i_WR_EN             write strobe for the whole beat
//   i_Lane_Valid        per-lane valid, thermometer from lane 0
//   Data_IN, i_Last_Byte, i_Length, i_SOP, i_End_Valid, i_Type
//                       per-lane entry fields, lane k at slice k
//   i_RD_EN             DLL ready, pops the head entry when o_Valid=1
//   o_Valid, o_Empty    head present / buffer empty
//   Data_Out, o_Last_Byte, o_Length, o_SOP, o_End_Valid, o_Type
//                       head entry fields
//   o_Full, o_Almost_Full, o_Count
//                       occupancy flags and count
//   o_Pkt_Avail         at least one complete packet is stored
//   o_Overflow          sticky, a write beat was dropped
module rx_buffer_mlane #(
    parameter int DATA_WIDTH       = 256,
    parameter int WR_LANES         = 2,
    parameter int DEPTH            = 16,
    parameter int ADDR_WIDTH       = $clog2(DEPTH),
    parameter int PACKET_LENGTH    = 11,
    parameter int SYMBOL_PTR_WIDTH = 5,
    parameter int AFULL_THRESH     = DEPTH - 4
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 i_Flush,
    input  logic                                 i_WR_EN,
    input  logic [WR_LANES-1:0]                  i_Lane_Valid,
    input  logic [WR_LANES*DATA_WIDTH-1:0]       Data_IN,
    input  logic [WR_LANES*SYMBOL_PTR_WIDTH-1:0] i_Last_Byte,
    input  logic [WR_LANES*PACKET_LENGTH-1:0]    i_Length,
    input  logic [WR_LANES-1:0]                  i_SOP,
    input  logic [WR_LANES-1:0]                  i_End_Valid,
    input  logic [WR_LANES-1:0]                  i_Type,
    input  logic                                 i_RD_EN,
    output logic                                 o_Valid,
    output logic                                 o_Empty,
    output logic [DATA_WIDTH-1:0]                Data_Out,
    output logic [SYMBOL_PTR_WIDTH-1:0]          o_Last_Byte,
    output logic [PACKET_LENGTH-1:0]             o_Length,
    output logic                                 o_SOP,
    output logic                                 o_End_Valid,
    output logic                                 o_Type,
    output logic                                 o_Full,
    output logic                                 o_Almost_Full,
    output logic [ADDR_WIDTH:0]                  o_Count,
    output logic                                 o_Pkt_Avail,
    output logic                                 o_Overflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    // Capacity in the widened width used for the room check, so that
    // count + lanes cannot wrap before the comparison.
    localparam logic [PTR_W:0] DEPTH_WIDE = (PTR_W + 1)'(DEPTH);

    // Entry storage, one array per field.
    logic [DATA_WIDTH-1:0]       mem_data      [DEPTH];
    logic [SYMBOL_PTR_WIDTH-1:0] mem_last_byte [DEPTH];
    logic [PACKET_LENGTH-1:0]    mem_length    [DEPTH];
    logic                        mem_sop       [DEPTH];
    logic                        mem_end_valid [DEPTH];
    logic                        mem_type      [DEPTH];

    // The pointer MSB tells full apart from empty when the addresses match.
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      pkt_cnt;
    logic                  overflow_q;

    logic [PTR_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [PTR_W-1:0]      lane_cnt;
    logic [PTR_W-1:0]      ev_cnt;
    logic                  beat_req;
    logic                  accept;
    logic                  drop;
    logic                  pop;
    logic                  pop_end;
    logic [WR_LANES-1:0]   lane_we;
    logic [ADDR_WIDTH-1:0] waddr [WR_LANES];

    assign count   = wr_ptr - rd_ptr;
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // Beat admission: the room check uses the occupancy before this edge,
    // so a pop in the same cycle never makes room for the write. A beat
    // that does not fit is dropped whole rather than partially written.
    always_comb begin
        lane_cnt = '0;
        ev_cnt   = '0;
        for (int k = 0; k < WR_LANES; k++) begin
            lane_cnt = lane_cnt + PTR_W'(i_Lane_Valid[k]);
        end
        beat_req = i_WR_EN && (lane_cnt != '0);
        accept   = beat_req && (({1'b0, count} + {1'b0, lane_cnt}) <= DEPTH_WIDE);
        drop     = beat_req && !accept;
        lane_we  = accept ? i_Lane_Valid : '0;
        for (int k = 0; k < WR_LANES; k++) begin
            waddr[k] = wr_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k);
            ev_cnt   = ev_cnt + PTR_W'(lane_we[k] & i_End_Valid[k]);
        end
        pop     = i_RD_EN && (count != '0);
        pop_end = pop && mem_end_valid[rd_addr];
    end

    // State update; reset and flush wipe the storage as well so the head
    // outputs read back as zero while empty.
    always_ff @(posedge CLK) begin
        if (RST || i_Flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_cnt    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]      <= '0;
                mem_last_byte[i] <= '0;
                mem_length[i]    <= '0;
                mem_sop[i]       <= 1'b0;
                mem_end_valid[i] <= 1'b0;
                mem_type[i]      <= 1'b0;
            end
        end else begin
            for (int k = 0; k < WR_LANES; k++) begin
                if (lane_we[k]) begin
                    mem_data[waddr[k]]      <= Data_IN[k*DATA_WIDTH +: DATA_WIDTH];
                    mem_last_byte[waddr[k]] <= i_Last_Byte[k*SYMBOL_PTR_WIDTH +: SYMBOL_PTR_WIDTH];
                    mem_length[waddr[k]]    <= i_Length[k*PACKET_LENGTH +: PACKET_LENGTH];
                    mem_sop[waddr[k]]       <= i_SOP[k];
                    mem_end_valid[waddr[k]] <= i_End_Valid[k];
                    mem_type[waddr[k]]      <= i_Type[k];
                end
            end
            if (accept) begin
                wr_ptr <= wr_ptr + lane_cnt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            pkt_cnt <= pkt_cnt + ev_cnt - PTR_W'(pop_end);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Show-ahead head and flags, all derived from registered state.
    always_comb begin
        o_Count       = count;
        o_Empty       = (count == '0);
        o_Valid       = (count != '0);
        o_Full        = (count == PTR_W'(DEPTH));
        o_Almost_Full = (count >= PTR_W'(AFULL_THRESH));
        o_Pkt_Avail   = (pkt_cnt != '0);
        o_Overflow    = overflow_q;
        Data_Out      = mem_data[rd_addr];
        o_Last_Byte   = mem_last_byte[rd_addr];
        o_Length      = mem_length[rd_addr];
        o_SOP         = mem_sop[rd_addr];
        o_End_Valid   = mem_end_valid[rd_addr];
        o_Type        = mem_type[rd_addr];
    end

endmodule

// File: doc/rx_buffer_mlane.md
# rx_buffer_mlane

Multi-lane successor to the single-output RX packet buffer at the end of the MAC RX path, between the deframer and the DLL interface. It accepts up to WR_LANES deframed entries per cycle (data plus packet sideband) and presents them one per cycle to the DLL in write order. Compared with the earlier buffer, it adds:
- full and almost-full flags
- overflow detection with whole-beat drop
- an occupancy count
- a complete-packet counter, so the DLL can wait until a whole packet is buffered before it starts reading.

## Interface
Parameters:
- DATA_WIDTH, 256, data bits per entry
- WR_LANES, 2, write lanes per cycle (1..4)
- DEPTH, 16, entries; power of two, DEPTH >= 2*WR_LANES
- ADDR_WIDTH, $clog2(DEPTH), entry address width
- PACKET_LENGTH, 11, length field width (DW)
- SYMBOL_PTR_WIDTH, 5, last-byte pointer width
- AFULL_THRESH, DEPTH-4, almost-full occupancy threshold

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- i_Flush  in  1  synchronous flush; same effect as RST
- i_WR_EN  in  1  write strobe
- i_Lane_Valid  in  WR_LANES  per-lane valid; must be thermometer from lane 0 (e.g. 01, 11)
- Data_IN  in  WR_LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_Last_Byte  in  WR_LANES*SYMBOL_PTR_WIDTH  per-lane last-byte pointer
- i_Length  in  WR_LANES*PACKET_LENGTH  per-lane packet length
- i_SOP, i_End_Valid, i_Type  in  WR_LANES each  per-lane flags
- i_RD_EN  in  1  DLL ready; pops the head entry when o_Valid=1
- o_Valid  out  1  head entry present (not empty)
- o_Empty  out  1  occupancy == 0
- Data_Out  out  DATA_WIDTH  head data
- o_Last_Byte, o_Length, o_SOP, o_End_Valid, o_Type  out  as above  head sideband
- o_Full  out  1  occupancy == DEPTH
- o_Almost_Full  out  1  occupancy >= AFULL_THRESH
- o_Count  out  ADDR_WIDTH+1  occupancy
- o_Pkt_Avail  out  1  at least one complete packet (End_Valid entry) stored
- o_Overflow  out  1  sticky; a write beat was dropped

## Operation
- **Storage**
  - Each entry is {data, last_byte, length, SOP, End_Valid, Type}.
  - Pointers wr_ptr and rd_ptr are ADDR_WIDTH+1 bits.
  - The address is the low ADDR_WIDTH bits and wraps modulo DEPTH. The MSB disambiguates full from empty.
- **Write**
  - n = number of set bits in i_Lane_Valid.
  - If i_WR_EN && n != 0 && (o_Count + n) <= DEPTH, lane k writes mem[(wr_ptr+k) mod DEPTH] for k < n, and wr_ptr += n.
  - The check uses the current-cycle o_Count. A read in the same cycle does not free space for that write.
  - Otherwise, with i_WR_EN && n != 0, the whole beat is dropped. No partial write occurs, and o_Overflow is set to 1 and held until RST or i_Flush.
  - A non-thermometer i_Lane_Valid is illegal. The bench asserts on it.
- **Read**
  - Show-ahead: the head outputs are driven combinationally from mem[rd_ptr].
  - If i_RD_EN && o_Valid, rd_ptr += 1. i_RD_EN while empty is ignored.
- **Occupancy:** o_Count = wr_ptr - rd_ptr (modulo 2^(ADDR_WIDTH+1)).
- **Packet counter**
  - pkt_cnt is ADDR_WIDTH+1 bits.
  - It adds the number of accepted lanes with End_Valid=1.
  - It subtracts 1 when the popped entry has End_Valid=1.
  - Simultaneous increment and decrement net out in the same cycle.
  - o_Pkt_Avail = (pkt_cnt != 0).
- **Priority:** RST > i_Flush > write/read.
  - RST or i_Flush clears both pointers, pkt_cnt, o_Overflow and all memory entries to 0.

## Timing
- Reset values: o_Valid=0, o_Empty=1, o_Full=0, o_Almost_Full=0 (AFULL_THRESH>0), o_Count=0, o_Pkt_Avail=0, o_Overflow=0. Data_Out and all head sideband are 0.
- Write-to-read latency is 1 cycle. An entry written at edge t is visible on the head outputs, with o_Valid=1, after edge t.
- All flags and o_Count are functions of registered state only, and update on the edge after the causing event.
- o_Overflow rises on the edge after the dropped beat.
- Full plus simultaneous read and write: the read pops and the write is dropped (overflow). The next cycle shows count DEPTH-1.
- Wrap-around: a 2-lane write at address DEPTH-1 places lane 1 at address 0.
- RST or i_Flush asserted mid-stream: the next cycle is empty, regardless of any i_WR_EN or i_RD_EN in that same cycle.

## Test plan
All scenarios use DEPTH=16, WR_LANES=2.
1. **Reset.** Assert RST for 2 cycles, then release. Require o_Empty=1, o_Count=0, Data_Out=0 and o_Overflow=0.
2. **Dual-lane write and in-order read.** Write {A,B} with i_Lane_Valid=11, then {C} with 01. Then hold i_RD_EN=1. Require heads A, B, C on consecutive cycles and the count sequence 3, 2, 1, 0.
3. **Wrap-around.** Write 15 single entries and read 15. Then write {X,Y} with 11. Require X stored at address 15 and Y at address 0, reading back as X then Y, with o_Count=2.
4. **Overflow.**
   - Fill to 15 entries and write with 11. Require the beat dropped, o_Count stays 15 and o_Overflow=1.
   - Then write with 01. Require o_Full=1 and o_Almost_Full=1.
   - Then i_Flush for 1 cycle. Require o_Overflow=0 and o_Count=0.
5. **Packet counter.**
   - Write 3 entries with End_Valid 0, 0, 1. Require o_Pkt_Avail=1 only after the third write.
   - Pop all 3 entries. Require o_Pkt_Avail=0 after the third pop.
   - Simultaneously popping one End_Valid entry while writing another keeps pkt_cnt=1.
6. **Reset mid-operation.** With 8 entries stored, assert RST together with i_WR_EN=1 and i_RD_EN=1. The next cycle must be fully empty with o_Pkt_Avail=0.
